// File: rtl/eth_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_pkg
// Description : Shared types and constants for the host-side Ethernet TX path.
//               Holds the drain FSM state encoding, the host write op-size
//               encoding, the minimum frame length used by optional padding
//               and the number of ping-pong slots.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_tx_pkg;

    typedef enum logic [0:0] {
        eIdle = 1'b0,
        eSend = 1'b1
    } tx_state_e;

    typedef enum logic [1:0] {
        eOp1B = 2'd0,
        eOp2B = 2'd1,
        eOp4B = 2'd2,
        eOp8B = 2'd3
    } op_size_e;

    localparam int min_frame_bytes_gp = 60;
    localparam int slot_count_gp      = 2;

    // Number of bytes touched by a host write of the given op size.
    function automatic int op_bytes(input logic [1:0] op_size);
        return 1 << op_size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_buffer_memory.sv
`default_nettype none
// ============================================================================
// Module      : tx_buffer_memory
// Description : Two-slot ping-pong packet buffer. The host side writes bytes
//               into the current write slot and commits it together with its
//               size; the drain side reads one beat at a time combinationally
//               from the current read slot and releases it when done.
// Ports       : clk_i/reset_n_i    clock, synchronous active-low reset
//               wr_*_i             byte-enabled host write (gated by ready_o)
//               commit_i/_size_i   commit write slot with its effective size
//               release_i          free the read slot
//               rd_beat_i          beat index to read from the read slot
//               ready_o            write slot is free
//               rd_v_o/rd_size_o   read slot committed / its stored size
//               rd_data_o          combinational beat data
// Revision    : 1.0 - initial release
// ============================================================================
module tx_buffer_memory
    import eth_tx_pkg::*;
#(
    parameter  int send_width_p   = 64,
    parameter  int buf_size_p     = 2048,
    localparam int addr_width_lp  = $clog2(buf_size_p),
    localparam int bytes_lp       = send_width_p / 8,
    localparam int byte_sel_lp    = $clog2(bytes_lp),
    localparam int beat_width_lp  = addr_width_lp - byte_sel_lp,
    localparam int size_width_lp  = addr_width_lp + 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     wr_v_i,
    input  logic [addr_width_lp-1:0] wr_addr_i,
    input  logic [1:0]               wr_op_size_i,
    input  logic [send_width_p-1:0]  wr_data_i,
    input  logic                     commit_i,
    input  logic [size_width_lp-1:0] commit_size_i,
    input  logic                     release_i,
    input  logic [beat_width_lp-1:0] rd_beat_i,
    output logic                     ready_o,
    output logic                     rd_v_o,
    output logic [size_width_lp-1:0] rd_size_o,
    output logic [send_width_p-1:0]  rd_data_o
);

    logic [7:0]               mem_q  [slot_count_gp][buf_size_p];
    logic [size_width_lp-1:0] size_q [slot_count_gp];
    logic [slot_count_gp-1:0] slot_v_q;
    logic                     wr_ptr_q;
    logic                     rd_ptr_q;
    logic [bytes_lp-1:0]      w_wr_be;

    // With two slots, the write slot is free exactly when fewer than two
    // slots are committed.
    assign ready_o   = ~slot_v_q[wr_ptr_q];
    assign rd_v_o    = slot_v_q[rd_ptr_q];
    assign rd_size_o = size_q[rd_ptr_q];

    always_comb begin
        w_wr_be = '0;
        for (int k = 0; k < bytes_lp; k++) begin
            w_wr_be[k] = (k < op_bytes(wr_op_size_i));
        end
    end

    // Payload storage carries no reset; only the slot bookkeeping does.
    always_ff @(posedge clk_i) begin
        if (wr_v_i && ready_o) begin
            for (int k = 0; k < bytes_lp; k++) begin
                if (w_wr_be[k]) begin
                    mem_q[wr_ptr_q][wr_addr_i + addr_width_lp'(k)] <= wr_data_i[8*k +: 8];
                end
            end
        end
    end

    // Commit always targets the free write slot and release the occupied
    // read slot, so the two updates never touch the same valid bit.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            slot_v_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int s = 0; s < slot_count_gp; s++) begin
                size_q[s] <= '0;
            end
        end else begin
            if (commit_i && ready_o) begin
                slot_v_q[wr_ptr_q] <= 1'b1;
                size_q[wr_ptr_q]   <= commit_size_i;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (release_i && rd_v_o) begin
                slot_v_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q           <= ~rd_ptr_q;
            end
        end
    end

    for (genvar k = 0; k < bytes_lp; k++) begin : g_rd_byte
        assign rd_data_o[8*k +: 8] = mem_q[rd_ptr_q][{rd_beat_i, byte_sel_lp'(k)}];
    end

endmodule
`default_nettype wire

// File: rtl/ethernet_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : ethernet_transmitter
// Description : Host-side Ethernet TX. Host writes fill a two-slot buffer,
//               send_i commits a slot, and a drain FSM streams the frame as
//               AXI-Stream beats toward the MAC with registered outputs.
// Config      : ETH_TX_MIN_FRAME_PAD_EN - pad non-empty frames to 60 bytes,
//               driving bytes beyond the committed size as zero.
// Ports       : clk_i, reset_n_i (sync, active-low)
//               buffer_write_*_i   host byte-enabled write port
//               tx_packet_size_i, send_i   commit size and command
//               ready_o            a write slot is free
//               tx_axis_*          AXI-Stream master toward the MAC
//               send_count_o       frames sent, wraps modulo 2^16
// Revision    : 1.0 - initial release
// ============================================================================
module ethernet_transmitter
    import eth_tx_pkg::*;
#(
    parameter  int send_width_p  = 64,
    parameter  int buf_size_p    = 2048,
    localparam int addr_width_lp = $clog2(buf_size_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      buffer_write_v_i,
    input  logic [addr_width_lp-1:0]  buffer_write_addr_i,
    input  logic [1:0]                buffer_write_op_size_i,
    input  logic [send_width_p-1:0]   buffer_write_data_i,
    input  logic [15:0]               tx_packet_size_i,
    input  logic                      send_i,
    output logic                      ready_o,
    output logic [send_width_p-1:0]   tx_axis_tdata_o,
    output logic [send_width_p/8-1:0] tx_axis_tkeep_o,
    output logic                      tx_axis_tvalid_o,
    input  logic                      tx_axis_tready_i,
    output logic                      tx_axis_tlast_o,
    output logic                      tx_axis_tuser_o,
    output logic [15:0]               send_count_o
);

    localparam int bytes_lp      = send_width_p / 8;
    localparam int byte_sel_lp   = $clog2(bytes_lp);
    localparam int beat_width_lp = addr_width_lp - byte_sel_lp;
    localparam int size_width_lp = addr_width_lp + 1;

    tx_state_e                state_q;
    logic                     tvalid_q;
    logic                     tlast_q;
    logic [send_width_p-1:0]  tdata_q;
    logic [bytes_lp-1:0]      tkeep_q;
    logic [beat_width_lp-1:0] beat_q;
    logic [15:0]              send_count_q;

    logic [size_width_lp-1:0] w_commit_size;
    logic                     w_rd_v;
    logic [size_width_lp-1:0] w_rd_size;
    logic [size_width_lp-1:0] w_eff_size;
    logic [addr_width_lp-1:0] w_eff_m1;
    logic [beat_width_lp-1:0] w_last_idx;
    logic [byte_sel_lp-1:0]   w_rem;
    logic [bytes_lp-1:0]      w_last_keep;
    logic [beat_width_lp-1:0] w_load_beat;
    logic                     w_load_last;
    logic [bytes_lp-1:0]      w_load_keep;
    logic [send_width_p-1:0]  w_rd_data;
    logic [send_width_p-1:0]  w_load_data;
    logic                     w_release;

    // Oversized requests are clamped to one full slot.
    assign w_commit_size = (tx_packet_size_i > 16'(buf_size_p))
                         ? size_width_lp'(buf_size_p)
                         : tx_packet_size_i[size_width_lp-1:0];

    tx_buffer_memory #(
        .send_width_p (send_width_p),
        .buf_size_p   (buf_size_p)
    ) u_buf (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .wr_v_i        (buffer_write_v_i),
        .wr_addr_i     (buffer_write_addr_i),
        .wr_op_size_i  (buffer_write_op_size_i),
        .wr_data_i     (buffer_write_data_i),
        .commit_i      (send_i),
        .commit_size_i (w_commit_size),
        .release_i     (w_release),
        .rd_beat_i     (w_load_beat),
        .ready_o       (ready_o),
        .rd_v_o        (w_rd_v),
        .rd_size_o     (w_rd_size),
        .rd_data_o     (w_rd_data)
    );

`ifdef ETH_TX_MIN_FRAME_PAD_EN
    assign w_eff_size = (w_rd_size != '0 && w_rd_size < size_width_lp'(min_frame_bytes_gp))
                      ? size_width_lp'(min_frame_bytes_gp)
                      : w_rd_size;

    // Bytes past the committed size are forced to zero so stale slot
    // contents never leak into the padding.
    always_comb begin
        w_load_data = w_rd_data;
        for (int k = 0; k < bytes_lp; k++) begin
            if ({1'b0, w_load_beat, byte_sel_lp'(k)} >= w_rd_size) begin
                w_load_data[8*k +: 8] = 8'h00;
            end
        end
    end
`else
    assign w_eff_size  = w_rd_size;
    assign w_load_data = w_rd_data;
`endif

    // Index of the final beat is (E-1)/B; E is at most one slot so E-1 fits
    // in the byte-address width.
    assign w_eff_m1    = addr_width_lp'(w_eff_size - size_width_lp'(1));
    assign w_last_idx  = beat_width_lp'(w_eff_m1 >> byte_sel_lp);
    assign w_rem       = w_eff_size[byte_sel_lp-1:0];
    assign w_last_keep = (w_rem == '0) ? '1
                       : ((bytes_lp'(1) << w_rem) - bytes_lp'(1));

    // Beat to present next: beat 0 when starting a frame, otherwise the
    // successor of the beat currently on the bus.
    assign w_load_beat = (state_q == eIdle) ? '0 : beat_q + beat_width_lp'(1);
    assign w_load_last = (w_load_beat == w_last_idx);
    assign w_load_keep = w_load_last ? w_last_keep : '1;

    // Empty frames are released straight from idle without any beat.
    assign w_release = ((state_q == eIdle) && w_rd_v && (w_eff_size == '0))
                     || ((state_q == eSend) && tx_axis_tready_i && tlast_q);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= eIdle;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            beat_q       <= '0;
            send_count_q <= '0;
        end else begin
            case (state_q)
                eIdle: begin
                    if (w_rd_v && (w_eff_size != '0)) begin
                        tdata_q  <= w_load_data;
                        tkeep_q  <= w_load_keep;
                        tlast_q  <= w_load_last;
                        beat_q   <= w_load_beat;
                        tvalid_q <= 1'b1;
                        state_q  <= eSend;
                    end
                end
                eSend: begin
                    if (tx_axis_tready_i) begin
                        if (tlast_q) begin
                            tvalid_q     <= 1'b0;
                            tlast_q      <= 1'b0;
                            send_count_q <= send_count_q + 16'd1;
                            state_q      <= eIdle;
                        end else begin
                            tdata_q <= w_load_data;
                            tkeep_q <= w_load_keep;
                            tlast_q <= w_load_last;
                            beat_q  <= w_load_beat;
                        end
                    end
                end
                default: state_q <= eIdle;
            endcase
        end
    end

    assign tx_axis_tdata_o  = tdata_q;
    assign tx_axis_tkeep_o  = tkeep_q;
    assign tx_axis_tvalid_o = tvalid_q;
    assign tx_axis_tlast_o  = tlast_q;
    assign tx_axis_tuser_o  = 1'b0;
    assign send_count_o     = send_count_q;

`ifndef SYNTHESIS
    a_write_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(buffer_write_v_i && !ready_o));
    a_send_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(send_i && !ready_o));
    a_write_aligned: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        buffer_write_v_i |-> ((32'(buffer_write_addr_i) % op_bytes(buffer_write_op_size_i)) == 0));
    a_op_size_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        buffer_write_v_i |-> (op_bytes(buffer_write_op_size_i) <= bytes_lp));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ethernet_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ethernet_transmitter
// Description : Self-checking bench for ethernet_transmitter (64-bit data).
//               Stimulus pushes expected beats into a scoreboard queue; a
//               monitor pops and compares every accepted AXIS beat and checks
//               that stalled beats stay stable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ethernet_transmitter;

    localparam int BUF = 2048;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_v = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [1:0]  wr_op = '0;
    logic [63:0] wr_data = '0;
    logic [15:0] pkt_size = '0;
    logic        send = 1'b0;
    logic        ready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        tlast;
    logic        tuser;
    logic [15:0] send_count;

    ethernet_transmitter dut (
        .clk_i                  (clk),
        .reset_n_i              (reset_n),
        .buffer_write_v_i       (wr_v),
        .buffer_write_addr_i    (wr_addr),
        .buffer_write_op_size_i (wr_op),
        .buffer_write_data_i    (wr_data),
        .tx_packet_size_i       (pkt_size),
        .send_i                 (send),
        .ready_o                (ready),
        .tx_axis_tdata_o        (tdata),
        .tx_axis_tkeep_o        (tkeep),
        .tx_axis_tvalid_o       (tvalid),
        .tx_axis_tready_i       (tready),
        .tx_axis_tlast_o        (tlast),
        .tx_axis_tuser_o        (tuser),
        .send_count_o           (send_count)
    );

    always #5 clk = ~clk;

    beat_t      sb_q[$];
    logic [7:0] keep_log[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         beats_seen = 0;
    int         exp_count = 0;
    bit         last_accept_seen = 1'b0;
    bit         stall = 1'b0;
    logic [72:0] held = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] pat(input int seed, input int idx);
        return 8'(seed * 29 + idx * 7 + (idx / 256) * 13) | 8'h01;
    endfunction

    function automatic logic [63:0] word(input int seed, input int addr, input int nbytes);
        logic [63:0] w = '0;
        for (int k = 0; k < nbytes; k++) w[8*k +: 8] = pat(seed, addr + k);
        return w;
    endfunction

    // Monitor: a beat seen at the falling edge with tvalid&tready is taken
    // by the DUT at the following rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall = 1'b0;
        end else begin
            if (stall && tvalid) check("stall_hold", {55'd0, tdata, tkeep, tlast}, {55'd0, held});
            if (tvalid && tready) begin
                beats_seen++;
                keep_log.push_back(tkeep);
                if (tlast) last_accept_seen = 1'b1;
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", 128'd1, 128'd0);
                end else begin
                    beat_t       e;
                    logic [63:0] m;
                    e = sb_q.pop_front();
                    for (int k = 0; k < 8; k++) m[8*k +: 8] = {8{e.keep[k]}};
                    check("beat", {55'd0, tdata & m, tkeep, tlast}, {55'd0, e.data & m, e.keep, e.last});
                end
            end
            stall = tvalid && !tready;
            held  = {tdata, tkeep, tlast};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int op, input logic [63:0] d);
        wr_v = 1'b1; wr_addr = 11'(a); wr_op = 2'(op); wr_data = d;
        tick();
        wr_v = 1'b0;
    endtask

    task automatic send_pkt(input int size);
        pkt_size = 16'(size); send = 1'b1;
        tick();
        send = 1'b0;
    endtask

    task automatic write_frame(input int seed, input int nbytes, input int op);
        int step = 1 << op;
        int lim = (nbytes > BUF) ? BUF : nbytes;
        for (int a = 0; a < lim; a += step) wr(a, op, word(seed, a, step));
    endtask

    task automatic push_frame(input int seed, input int size, input int max_beats, output int nb);
        int s = (size > BUF) ? BUF : size;
        int e = s;
`ifdef ETH_TX_MIN_FRAME_PAD_EN
        if (e > 0 && e < 60) e = 60;
`endif
        nb = (e + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            beat_t t;
            t.last = (b == nb - 1);
            t.keep = (t.last && (e % 8) != 0) ? 8'((1 << (e % 8)) - 1) : 8'hFF;
            for (int k = 0; k < 8; k++) t.data[8*k +: 8] = (b*8 + k < s) ? pat(seed, b*8 + k) : 8'h00;
            if (max_beats < 0 || b < max_beats) sb_q.push_back(t);
        end
        if (max_beats < 0 && nb > 0) exp_count++;
    endtask

    task automatic clear_log();
        keep_log.delete();
        beats_seen = 0;
    endtask

    task automatic drain(input string name, input int limit);
        bit done = 1'b0;
        tready = 1'b1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (sb_q.size() == 0 && !tvalid) begin done = 1'b1; break; end
        end
        check({name, "_drain"}, 128'(done), 128'd1);
    endtask

    task automatic wait_valid(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tvalid) begin ok = 1'b1; break; end
            tick();
        end
        check({name, "_wait_valid"}, 128'(ok), 128'd1);
    endtask

    initial begin
        int nb;
        int cnt_before;
        bit saw;
        bit ok;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  128'(ready),      128'd1);
        check("rst_tvalid", 128'(tvalid),     128'd0);
        check("rst_tlast",  128'(tlast),      128'd0);
        check("rst_tdata",  128'(tdata),      128'd0);
        check("rst_tkeep",  128'(tkeep),      128'd0);
        check("rst_tuser",  128'(tuser),      128'd0);
        check("rst_count",  128'(send_count), 128'd0);
        reset_n = 1'b1;
        tick();

        // Single 20-byte frame using 8B and 4B writes
        clear_log();
        tready = 1'b0;
        wr(0, 3, word(1, 0, 8));
        wr(8, 3, word(1, 8, 8));
        wr(16, 2, word(1, 16, 4));
        push_frame(1, 20, -1, nb);
        send_pkt(20);
        check("t1_valid_n1", 128'(tvalid), 128'd0);
        tick();
        check("t1_valid_n2", 128'(tvalid), 128'd1);
        drain("t1", 100);
        check("t1_beats", 128'(beats_seen), 128'(nb));
`ifndef ETH_TX_MIN_FRAME_PAD_EN
        check("t1_beats_const", 128'(beats_seen), 128'd3);
        if (keep_log.size() == 3)
            check("t1_keeps", {104'd0, keep_log[0], keep_log[1], keep_log[2]}, 128'hFFFF0F);
        else
            check("t1_keeps_len", 128'(keep_log.size()), 128'd3);
`endif
        check("t1_count", 128'(send_count), 128'd1);

        // Back-pressure on a 16-byte frame built from 1B and 2B writes
        clear_log();
        tready = 1'b0;
        for (int a = 0; a < 8; a++) wr(a, 0, word(2, a, 1));
        for (int a = 8; a < 16; a += 2) wr(a, 1, word(2, a, 2));
        push_frame(2, 16, -1, nb);
        send_pkt(16);
        wait_valid("t2");
        tready = 1'b1; tick();
        tready = 1'b0; tick();
        tick();
        tready = 1'b1;
        drain("t2", 100);
        check("t2_beats", 128'(beats_seen), 128'(nb));
        check("t2_count", 128'(send_count), 128'(exp_count));

        // Ping-pong: two committed frames, then release timing
        clear_log();
        tready = 1'b0;
        write_frame(3, 8, 3);
        push_frame(3, 8, -1, nb);
        send_pkt(8);
        write_frame(4, 8, 3);
        push_frame(4, 8, -1, nb);
        send_pkt(8);
        check("t3_ready_low", 128'(ready), 128'd0);
        last_accept_seen = 1'b0;
        tready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (last_accept_seen) begin ok = 1'b1; break; end
        end
        check("t3_first_tlast", 128'(ok), 128'd1);
        check("t3_ready_back", 128'(ready), 128'd1);
        check("t3_idle_gap", 128'(tvalid), 128'd0);
        tick();
        check("t3_second_valid", 128'(tvalid), 128'd1);
        drain("t3", 100);
        check("t3_count", 128'(send_count), 128'(exp_count));

        // Zero-size frame: no beats, no count
        clear_log();
        cnt_before = int'(send_count);
        tready = 1'b1;
        send_pkt(0);
        saw = 1'b0;
        repeat (6) begin
            if (tvalid) saw = 1'b1;
            tick();
        end
        check("t4_no_valid", 128'(saw), 128'd0);
        check("t4_count", 128'(send_count), 128'(cnt_before));
        check("t4_ready", 128'(ready), 128'd1);

        // Full-slot frame: 2048 bytes
        clear_log();
        write_frame(5, 2048, 3);
        push_frame(5, 2048, -1, nb);
        send_pkt(2048);
        drain("t5", 3000);
        check("t5_beats", 128'(beats_seen), 128'd256);
        if (keep_log.size() == 256) check("t5_last_keep", 128'(keep_log[255]), 128'hFF);
        check("t5_count", 128'(send_count), 128'(exp_count));

        // Oversized request clamps to one slot
        clear_log();
        write_frame(6, 4000, 3);
        push_frame(6, 4000, -1, nb);
        send_pkt(4000);
        drain("t6", 3000);
        check("t6_beats", 128'(beats_seen), 128'd256);
        check("t6_count", 128'(send_count), 128'(exp_count));

`ifdef ETH_TX_MIN_FRAME_PAD_EN
        // Short frame padded to 60 bytes with zero fill
        clear_log();
        write_frame(7, 64, 3);
        push_frame(7, 14, -1, nb);
        send_pkt(14);
        drain("t7", 100);
        check("t7_beats", 128'(beats_seen), 128'd8);
        if (keep_log.size() == 8) check("t7_last_keep", 128'(keep_log[7]), 128'h0F);
`endif

        // Reset in the middle of a 10-beat frame after two beats
        clear_log();
        tready = 1'b0;
        write_frame(8, 80, 3);
        push_frame(8, 80, 2, nb);
        send_pkt(80);
        wait_valid("t8");
        tready = 1'b1;
        tick();
        tick();
        tready = 1'b0;
        reset_n = 1'b0;
        tick();
        check("t8_tvalid", 128'(tvalid), 128'd0);
        check("t8_tlast", 128'(tlast), 128'd0);
        check("t8_count", 128'(send_count), 128'd0);
        check("t8_ready", 128'(ready), 128'd1);
        check("t8_beats", 128'(beats_seen), 128'd2);
        check("t8_sb_empty", 128'(sb_q.size()), 128'd0);
        reset_n = 1'b1;
        tick();

        // Operation resumes after reset: 3-byte frame from 1B writes
        clear_log();
        exp_count = 0;
        for (int a = 0; a < 3; a++) wr(a, 0, word(9, a, 1));
        push_frame(9, 3, -1, nb);
        send_pkt(3);
        drain("t9", 100);
        check("t9_beats", 128'(beats_seen), 128'(nb));
        check("t9_count", 128'(send_count), 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ethernet_transmitter.md
# ethernet_transmitter

Host-side Ethernet TX block. A CPU-facing write port fills a two-slot packet buffer; a send command commits the packet size and hands the slot to a drain FSM, which streams the frame out as AXI-Stream beats toward the MAC. Mirror of the receive path: host writes, MAC reads.

## Interface
- send_width_p, 64, AXIS data width in bits; 32 or 64 only.
- buf_size_p, 2048, bytes per slot.
- addr_width_lp, $clog2(buf_size_p), local, byte address width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous, active-low reset.
- buffer_write_v_i  in  1  host write strobe.
- buffer_write_addr_i  in  addr_width_lp  byte address; must be aligned to the op size.
- buffer_write_op_size_i  in  2  access size: 0=1B, 1=2B, 2=4B, 3=8B (3 illegal when send_width_p=32).
- buffer_write_data_i  in  send_width_p  LSB-aligned write data.
- tx_packet_size_i  in  16  frame length in bytes; sampled with send_i.
- send_i  in  1  commit the write slot for transmission.
- ready_o  out  1  a write slot is free; writes and send_i are legal.
- tx_axis_tdata_o  out  send_width_p  beat data.
- tx_axis_tkeep_o  out  send_width_p/8  byte valid mask, contiguous from bit 0.
- tx_axis_tvalid_o  out  1  beat valid.
- tx_axis_tready_i  in  1  MAC accepts the beat.
- tx_axis_tlast_o  out  1  final beat of the frame.
- tx_axis_tuser_o  out  1  constant 0; the whole frame is buffered, so no underrun is possible.
- send_count_o  out  16  frames sent; wraps modulo 2^16.

## Operation
- Two slots in a ping-pong arrangement:
  - Write slot is owned by the host.
  - Read slot is owned by the drain FSM.
  - ready_o = 1 while fewer than 2 slots are committed.
- Writes are byte-enabled per op size into the current write slot. A write with ready_o=0 is ignored and fires a simulation assertion.
- send_i with ready_o=1 commits the slot and its size, and advances the write pointer. send_i with ready_o=0 is ignored and fires an assertion.
- If buffer_write_v_i and send_i arrive in the same cycle, the write lands in the slot being committed.
- Size handling:
  - Effective size S = min(tx_packet_size_i, buf_size_p).
  - S=0: the slot is released with no beats sent and send_count_o is not incremented.
- Beat arithmetic:
  - bytes_per_beat B = send_width_p/8.
  - Beat count = ceil(S/B).
  - Last-beat tkeep = (1<<(S mod B))-1, or all ones if S mod B = 0.
  - Every other beat has tkeep all ones.
- Drain FSM states:
  - eIdle: when the read slot is committed and S>0, load beat 0 into the output register and go to eSend. When S=0, release the slot and stay in eIdle.
  - eSend: tvalid=1. On tvalid&tready with no tlast, load the next beat in the same edge. On tvalid&tready with tlast, release the slot, increment send_count_o, and go to eIdle.
- tx_buffer_memory read is combinational. The output register holds tdata/tkeep/tlast.
- AXIS rule: tdata, tkeep and tlast are held stable while tvalid=1 and tready=0.

## Timing
- Reset values: ready_o=1, tvalid=0, tlast=0, tdata=0, tkeep=0, tuser=0, send_count_o=0. The FSM is in eIdle and both slots are empty.
- send_i at cycle N with the FSM idle → slot is visible at N+1, first beat has tvalid=1 at N+2.
- Within a frame, a beat can be accepted every cycle.
- Between frames there is exactly one idle cycle: last accept at M → next frame's first beat valid at M+2.
- Slot release at the last-accept edge M → ready_o=1 at M+1 if both slots had been full.
- Reset asserted mid-frame: tvalid drops in the next cycle, both slots are emptied, and the in-flight frame is discarded with no tlast.

## Configuration
- ETH_TX_MIN_FRAME_PAD_EN defined:
  - Effective size = max(S, 60) for S>0.
  - Bytes at index ≥ S are driven as 0 regardless of buffer contents.
- ETH_TX_MIN_FRAME_PAD_EN undefined: effective size is S, with no padding.

## Structure
- eth_tx_pkg holds:
  - the FSM state enum (eIdle, eSend);
  - the op-size enum;
  - min_frame_bytes_gp = 60;
  - the slot count = 2.
- Sub-module tx_buffer_memory contains:
  - two slots with byte-enable writes;
  - committed-size storage;
  - slot valid/ready pointers;
  - the combinational read port.
- ethernet_transmitter contains the drain FSM, beat counter, tkeep/tlast generation and send counter.

## Test plan
- Single frame, width 64: write 20 bytes, send_i size=20 → 3 beats, tkeep FF, FF, 0F, tlast on beat 3, send_count_o=1.
- Back-pressure: tready toggles 1,0,0,1 during a 16-byte frame → tdata/tkeep stable across the stall, 2 beats total, no beat lost or duplicated.
- Ping-pong: commit two frames of 8 bytes back-to-back → ready_o=0 after the second send_i; ready_o returns to 1 the cycle after frame 1's tlast; frame 2's first beat is valid 2 cycles after frame 1's tlast.
- Edge sizes: size=0 → no tvalid and count unchanged. Size 2048 → 256 beats, last tkeep FF. Size 4000 → clamped to 2048.
- Padding (ETH_TX_MIN_FRAME_PAD_EN defined): size=14 → 8 beats, last tkeep 0F, bytes 14–59 zero.
- Reset mid-frame: reset_n_i low after beat 2 of 10 → tvalid=0, send_count_o=0 and ready_o=1 after release.
